i2s_tx_serializer: RTL and testbench

Transmit serializer for the APB I2S block. It accepts stereo sample pairs from the register/FIFO side through a valid/ready handshake. It follows the word-select line produced by the WS generator and shifts each channel MSB-first onto the serial data line with the standard I2S one-bit delay. It sits directly downstream of the WS generator and drives the SD pad.

---
 rtl/i2s_pkg.sv | 33 +++
 rtl/i2s_tx_shifter.sv | 55 +++++
 rtl/i2s_tx_serializer.sv | 212 +++++++++++++++++++++
 tb/tb_i2s_tx_serializer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// -----------------------------------------------------------------------------
// i2s_pkg
// Shared definitions for the I2S transmit path: slot geometry, the transmit
// state encoding and the stereo pair container used by the holding and active
// pair registers.
// -----------------------------------------------------------------------------
package i2s_pkg;

  localparam int SLOT_W = 32;  // bit clocks per channel slot
  localparam int CNT_W  = 5;   // width of the in-slot bit counter

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    LEFT,
    RIGHT
  } tx_state_e;

  // Both channels stored already left-justified in a full slot, so a load
  // into the shifter needs no further alignment.
  typedef struct packed {
    logic [SLOT_W-1:0] left;
    logic [SLOT_W-1:0] right;
  } stereo_pair_t;

  // Place a w-bit sample (held in the low bits of s) at the top of the slot,
  // zero padded below.
  function automatic logic [SLOT_W-1:0] left_justify(input logic [SLOT_W-1:0] s,
                                                     input int w);
    return s << (SLOT_W - w);
  endfunction

endpackage

// File: rtl/i2s_tx_shifter.sv
// -----------------------------------------------------------------------------
// i2s_tx_shifter
// 32-bit load/shift register feeding the serial data line MSB-first.
// Updates on the falling edge of the bit clock.
//
// Ports:
//   i_tclk   bit clock (falling edge active)
//   i_rst    asynchronous active-high reset
//   i_clear  zero the register (highest priority)
//   i_load   load i_data
//   i_shift  shift left by one, zero fill
//   i_data   left-justified slot data to load
//   o_msb    current MSB of the register
// -----------------------------------------------------------------------------
module i2s_tx_shifter
  import i2s_pkg::*;
(
  input  logic              i_tclk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [SLOT_W-1:0] i_data,
  output logic              o_msb
);

  logic [SLOT_W-1:0] shift_q;
  logic [SLOT_W-1:0] shift_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; a missing default infers a latch.
    shift_d = shift_q;
    if (i_clear) begin
      shift_d = '0;
    end else if (i_load) begin
      shift_d = i_data;
    end else if (i_shift) begin
      shift_d = {shift_q[SLOT_W-2:0], 1'b0};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(negedge i_tclk or posedge i_rst) begin
    if (i_rst) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign o_msb = shift_q[SLOT_W-1];

endmodule

// File: rtl/i2s_tx_serializer.sv
// -----------------------------------------------------------------------------
// i2s_tx_serializer
// I2S transmit serializer. Accepts stereo pairs over valid/ready, follows the
// word-select line from the WS generator and shifts each channel MSB-first on
// o_sd with the I2S one-bit delay (the WS edge is detected one falling edge
// after it happens, and the MSB is driven at that detection edge).
//
// Optional feature: define I2S_TX_UNDERRUN_CNT_EN to add o_underrun_cnt, a
// 16-bit saturating count of underrun pulses, cleared only by i_rst.
//
// Ports:
//   i_tclk          bit clock; all flops update on its falling edge
//   i_rst           asynchronous active-high reset
//   i_enable        transmit enable (also gates the WS generator)
//   i_ws            word select, 0 = left, 1 = right
//   i_valid         sample pair valid
//   i_left/i_right  two's complement samples, DATA_W bits each
//   o_ready         holding register empty
//   o_sd            serial data
//   o_underrun      one-edge pulse when a left slot starts with no pair held
//   o_underrun_cnt  saturating underrun count (I2S_TX_UNDERRUN_CNT_EN only)
// -----------------------------------------------------------------------------
module i2s_tx_serializer
  import i2s_pkg::*;
#(
  parameter int DATA_W = 16  // legal range 8..32
) (
  input  logic              i_tclk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_ws,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_left,
  input  logic [DATA_W-1:0] i_right,
  output logic              o_ready,
  output logic              o_sd,
  output logic              o_underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       o_underrun_cnt
`endif
);

  tx_state_e         state_q, state_d;
  logic              ws_d_q, ws_d_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              full_q, full_d;
  stereo_pair_t      hold_q, hold_d;
  stereo_pair_t      active_q, active_d;
  logic              underrun_q, underrun_d;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0]       ucnt_q, ucnt_d;
`endif

  logic              left_start;
  logic              right_start;
  logic              sh_clear;
  logic              sh_load;
  logic              sh_shift;
  logic [SLOT_W-1:0] sh_data;
  logic              sh_msb;

  // A WS edge is seen as a mismatch between the live line and its copy from
  // the previous edge.
  assign left_start  = ws_d_q & ~i_ws;
  assign right_start = ~ws_d_q & i_ws;

  // ---------------------------------------------------------------------------
  // State register and datapath flops
  // ---------------------------------------------------------------------------
  always_ff @(negedge i_tclk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      ws_d_q     <= 1'b0;
      bit_cnt_q  <= '0;
      full_q     <= 1'b0;
      active_q   <= '0;
      underrun_q <= 1'b0;
`ifdef I2S_TX_UNDERRUN_CNT_EN
      ucnt_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ws_d_q     <= ws_d_d;
      bit_cnt_q  <= bit_cnt_d;
      full_q     <= full_d;
      active_q   <= active_d;
      underrun_q <= underrun_d;
`ifdef I2S_TX_UNDERRUN_CNT_EN
      ucnt_q     <= ucnt_d;
`endif
    end
  end

  // NOTE: the held pair is pure data qualified by full_q, so it carries no
  // reset; only the control flag that says it is valid needs one.
  always_ff @(negedge i_tclk) begin
    hold_q <= hold_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (!i_enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  state_d = SYNC;
        // Right starts are ignored here so a frame always opens on the left.
        SYNC:  if (left_start) state_d = LEFT;
        LEFT,
        RIGHT: begin
          if (left_start) begin
            state_d = LEFT;
          end else if (right_start) begin
            state_d = RIGHT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: holding register, active pair, shifter control, underrun
  // ---------------------------------------------------------------------------
  always_comb begin
    ws_d_d     = i_ws;
    full_d     = full_q;
    hold_d     = hold_q;
    active_d   = active_q;
    underrun_d = 1'b0;
    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
    sh_clear   = 1'b0;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    sh_data    = '0;

    if (state_d == IDLE || state_d == SYNC) begin
      // Outside a frame the shifter stays empty and any active pair is dropped.
      sh_clear  = 1'b1;
      active_d  = '0;
      bit_cnt_d = '0;
    end else if (state_d == LEFT && left_start) begin
      if (full_q) begin
        active_d = hold_q;
        full_d   = 1'b0;
      end else begin
        active_d   = '0;
        underrun_d = 1'b1;
      end
      sh_load   = 1'b1;
      sh_data   = active_d.left;
      bit_cnt_d = '0;
    end else if (state_d == RIGHT && right_start) begin
      sh_load   = 1'b1;
      sh_data   = active_q.right;
      bit_cnt_d = '0;
    end else begin
      sh_shift = 1'b1;
    end

    // Accept uses the pre-edge full flag; it can never collide with a consume
    // because o_ready is low whenever a consume is possible.
    if (i_valid && !full_q) begin
      full_d       = 1'b1;
      hold_d.left  = left_justify(SLOT_W'(i_left), DATA_W);
      hold_d.right = left_justify(SLOT_W'(i_right), DATA_W);
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun_d && ucnt_q != 16'hFFFF) begin
      ucnt_d = ucnt_q + 16'd1;
    end
  end
`endif

  i2s_tx_shifter u_shifter (
    .i_tclk  (i_tclk),
    .i_rst   (i_rst),
    .i_clear (sh_clear),
    .i_load  (sh_load),
    .i_shift (sh_shift),
    .i_data  (sh_data),
    .o_msb   (sh_msb)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    o_ready    = !full_q;
    o_underrun = underrun_q;
    o_sd       = 1'b0;
    // Only slot states drive data; the bit counter blanks anything past the
    // sample width even if a slot runs long.
    if ((state_q == LEFT || state_q == RIGHT) &&
        ({1'b0, bit_cnt_q} < 6'(DATA_W))) begin
      o_sd = sh_msb;
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  assign o_underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_i2s_tx_serializer
// Self-checking bench for i2s_tx_serializer (DATA_W = 16). The bench plays
// the WS generator (64 clocks per frame, gated by i_enable), keeps a
// slot-level behavioural model of the serial stream and compares the DUT to
// it on every rising edge, with literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_i2s_tx_serializer;

  localparam int DW = 16;

  logic          i_tclk = 1'b0;
  logic          i_rst;
  logic          i_enable;
  logic          i_ws;
  logic          i_valid;
  logic [DW-1:0] i_left;
  logic [DW-1:0] i_right;
  logic          o_ready;
  logic          o_sd;
  logic          o_underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0]   o_underrun_cnt;
`endif

  always #5 i_tclk = ~i_tclk;

  i2s_tx_serializer #(.DATA_W(DW)) dut (
    .i_tclk     (i_tclk),
    .i_rst      (i_rst),
    .i_enable   (i_enable),
    .i_ws       (i_ws),
    .i_valid    (i_valid),
    .i_left     (i_left),
    .i_right    (i_right),
    .o_ready    (o_ready),
    .o_sd       (o_sd),
    .o_underrun (o_underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    .o_underrun_cnt (o_underrun_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: tracks which sample is on the line and how many bits
  // into the slot we are, and derives the expected bit arithmetically.
  // ---------------------------------------------------------------------------
  bit            m_ws_prev, m_armed, m_in_frame, m_full, m_underrun;
  logic [DW-1:0] m_hold_l, m_hold_r, m_cur, m_right_pend;
  int            m_idx, m_cnt;

  task automatic m_reset();
    m_ws_prev = 0; m_armed = 0; m_in_frame = 0; m_full = 0; m_underrun = 0;
    m_hold_l = '0; m_hold_r = '0; m_cur = '0; m_right_pend = '0;
    m_idx = 0; m_cnt = 0;
  endtask

  task automatic m_step();
    bit ls, rs, was_full;
    ls = m_ws_prev && !i_ws;
    rs = !m_ws_prev && i_ws;
    was_full = m_full;
    m_underrun = 0;
    if (!i_enable) begin
      m_armed = 0;
      m_in_frame = 0;
    end else if (!m_armed) begin
      m_armed = 1;
    end else if (ls) begin
      m_in_frame = 1;
      m_idx = 0;
      if (m_full) begin
        m_cur = m_hold_l; m_right_pend = m_hold_r; m_full = 0;
      end else begin
        m_cur = '0; m_right_pend = '0; m_underrun = 1;
        if (m_cnt < 65535) m_cnt++;
      end
    end else if (rs && m_in_frame) begin
      m_cur = m_right_pend;
      m_idx = 0;
    end else begin
      m_idx++;
    end
    if (i_valid && !was_full) begin
      m_full = 1; m_hold_l = i_left; m_hold_r = i_right;
    end
    m_ws_prev = i_ws;
  endtask

  always @(negedge i_tclk or posedge i_rst) begin
    if (i_rst) m_reset();
    else       m_step();
  end

  function automatic logic exp_sd();
    if (m_in_frame && m_idx < DW) return m_cur[DW-1-m_idx];
    return 1'b0;
  endfunction

  bit cmp_en = 0;

  always @(posedge i_tclk) begin
    if (cmp_en) begin
      check("cyc_sd",       32'(o_sd),       32'(exp_sd()));
      check("cyc_ready",    32'(o_ready),    32'(!m_full));
      check("cyc_underrun", 32'(o_underrun), 32'(m_underrun));
`ifdef I2S_TX_UNDERRUN_CNT_EN
      check("cyc_ucnt",     32'(o_underrun_cnt), 32'(m_cnt));
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: one call = one bit clock; also acts as WS generator.
  // ---------------------------------------------------------------------------
  logic [5:0]  wcnt;
  logic [63:0] sd_hist;
  bit          prev_ready, last_acc;
  int          acc_cnt, upulse_cnt;

  task automatic cycle();
    prev_ready = o_ready;
    @(posedge i_tclk);
    last_acc = i_valid && prev_ready;
    if (last_acc) acc_cnt++;
    sd_hist = {sd_hist[62:0], o_sd};
    if (o_underrun) upulse_cnt++;
    if (i_enable) wcnt = wcnt + 6'd1;
    else          wcnt = '0;
    i_ws = i_enable ? wcnt[5] : 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // Advance until the WS generator has just driven the falling (left) edge.
  task automatic frame_sync();
    int guard = 0;
    do begin
      cycle();
      guard++;
    end while (wcnt != 6'd0 && guard < 100);
    check("frame_sync_wcnt", 32'(wcnt), 32'd0);
  endtask

  function automatic logic [DW-1:0] pl(input int k);
    return 16'(32'h8001 + k * 32'h0F11);
  endfunction

  function automatic logic [DW-1:0] pr(input int k);
    return 16'(32'h7E3C ^ (k << 4));
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    i_rst = 1; i_enable = 0; i_ws = 0; i_valid = 0; i_left = '0; i_right = '0;
    wcnt = '0; sd_hist = '0; acc_cnt = 0; upulse_cnt = 0; k = 0;

    // Reset state
    run(3);
    check("rst_sd",       32'(o_sd),       32'd0);
    check("rst_ready",    32'(o_ready),    32'd1);
    check("rst_underrun", 32'(o_underrun), 32'd0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("rst_ucnt",     32'(o_underrun_cnt), 32'd0);
`endif
    i_rst = 0;
    cmp_en = 1;
    run(2);

    // Enable: a right start in SYNC must stay silent
    i_enable = 1; wcnt = '0; i_ws = 0;
    sd_hist = '0;
    run(40);
    check("sync_silent", 32'(sd_hist != 64'd0), 32'd0);
    check("sync_ready",  32'(o_ready), 32'd1);

    // Push A5F0/0F0F before the first left start
    i_valid = 1; i_left = 16'hA5F0; i_right = 16'h0F0F;
    cycle();
    i_valid = 0;
    check("ready_after_accept", 32'(o_ready), 32'd0);
    frame_sync();
    cycle();
    check("ready_after_consume", 32'(o_ready),    32'd1);
    check("no_underrun_full",    32'(o_underrun), 32'd0);
    run(15);
    check("left_bits",  32'(sd_hist[15:0]), 32'h0000A5F0);
    run(16);
    check("left_pad",   32'(sd_hist[15:0]), 32'h0);
    run(16);
    check("right_bits", 32'(sd_hist[15:0]), 32'h00000F0F);
    run(16);
    check("right_pad",  32'(sd_hist[15:0]), 32'h0);

    // Underrun frame
    upulse_cnt = 0; sd_hist = '0;
    cycle();
    check("underrun_pulse", 32'(o_underrun), 32'd1);
    run(63);
    check("underrun_silent", 32'(sd_hist != 64'd0), 32'd0);
    check("underrun_once",   32'(upulse_cnt), 32'd1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("underrun_cnt_1",  32'(o_underrun_cnt), 32'd1);
`endif

    // Streaming: new pair offered continuously for 8 frames
    i_valid = 1; k = 0; i_left = pl(0); i_right = pr(0); acc_cnt = 0;
    for (int f = 0; f < 8; f++) begin
      for (int c = 0; c < 64; c++) begin
        cycle();
        if (last_acc) begin
          k++;
          i_left = pl(k); i_right = pr(k);
        end
        if (c == 15) check("stream_left",  32'(sd_hist[15:0]), 32'(f == 0 ? 16'h0 : pl(f - 1)));
        if (c == 47) check("stream_right", 32'(sd_hist[15:0]), 32'(f == 0 ? 16'h0 : pr(f - 1)));
      end
    end
    i_valid = 0;
    check("stream_accepts", 32'(acc_cnt), 32'd8);

    // Drop enable mid-left slot with a pair held
    run(5);
    i_valid = 1; i_left = 16'hC3A5; i_right = 16'h5A3C;
    cycle();
    i_valid = 0;
    run(4);
    i_enable = 0; wcnt = '0; i_ws = 0;
    cycle();
    check("disable_sd",   32'(o_sd),    32'd0);
    check("disable_held", 32'(o_ready), 32'd0);
    run(19);
    i_enable = 1; wcnt = '0; i_ws = 0;
    sd_hist = '0;
    run(64);
    check("resume_silent", 32'(sd_hist != 64'd0), 32'd0);
    check("resume_held",   32'(o_ready), 32'd0);
    run(16);
    check("resume_left",  32'(sd_hist[15:0]), 32'h0000C3A5);
    run(32);
    check("resume_right", 32'(sd_hist[15:0]), 32'h00005A3C);
    run(8);
    i_valid = 1; i_left = 16'hFFFF; i_right = 16'hFFFF;
    cycle();
    i_valid = 0;
    run(7);

    // Reset mid-right slot with another pair held
    run(5);
    i_valid = 1; i_left = 16'h1357; i_right = 16'h2468;
    cycle();
    i_valid = 0;
    run(34);
    check("pre_reset_sd", 32'(o_sd), 32'd1);
    #2 i_rst = 1;
    #1;
    check("mid_rst_sd",       32'(o_sd),       32'd0);
    check("mid_rst_ready",    32'(o_ready),    32'd1);
    check("mid_rst_underrun", 32'(o_underrun), 32'd0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("mid_rst_ucnt",     32'(o_underrun_cnt), 32'd0);
`endif
    run(3);
    i_rst = 0;
    frame_sync();
    cycle();
    check("post_rst_underrun", 32'(o_underrun), 32'd1);
    check("post_rst_ready",    32'(o_ready),    32'd1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("post_rst_ucnt",     32'(o_underrun_cnt), 32'd1);
`endif
    run(64);

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
